branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and mispredict-recovery controller for the PC-select path.
- IF stage: looks up a direct-mapped BTB with 2-bit saturating counters and supplies the predicted next PC.
- ID stage: compares the resolved branch/jump outcome (from branch resolution) against the carried prediction; on a miss it raises flush and a redirect PC, then trains the tables.
- Also keeps branch and mispredict performance counters.

Parameters:
- WIDTH_PC, 32, PC/target width.
- INDEX_BITS, 4, BTB index width; ENTRIES = 2^INDEX_BITS.
- TAG_BITS, 10, tag width; tag = PC[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2].
- WIDTH_PERF, 32, performance counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_IF  in  WIDTH_PC  fetch PC.
- predTaken_IF  out  1  prediction for pc_IF.
- predPC_IF  out  WIDTH_PC  predicted next PC.
- stall_ID  in  1  ID stage held; suppresses resolve.
- resolve_valid  in  1  ID holds a control-flow instruction this cycle.
- isJump  in  1  1 = jal/jalr (unconditional), 0 = conditional branch.
- pc_ID  in  WIDTH_PC  PC of the resolving instruction.
- actualTaken  in  1  resolved direction (PCSel == JUMP).
- actualTarget  in  WIDTH_PC  resolved target (branchPC).
- predTaken_ID  in  1  prediction carried down the pipe with the instruction.
- predPC_ID  in  WIDTH_PC  predicted PC carried with the instruction.
- flush  out  1  squash IF/ID contents.
- redirectPC  out  WIDTH_PC  correct next PC when flush = 1.
- branchCount  out  WIDTH_PERF  resolved control-flow instructions.
- mispredCount  out  WIDTH_PERF  mispredictions.

Behaviour:
- Per-entry state: valid (1), tag, target, ctr (2). Counter encoding: SNT = 00, WNT = 01, WT = 10, ST = 11.
- Reset (synchronous, overrides everything): all valid = 0, ctr = WNT, tag/target = 0, both perf counters = 0. Outputs during reset: predTaken_IF = 0, predPC_IF = pc_IF + 4, flush = 0, redirectPC = 0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - predTaken_IF = hit && ctr[1].
  - predPC_IF = predTaken_IF ? target[idx] : pc_IF + 4.
- Resolve event: res = resolve_valid && !stall_ID && !rst.
- Mispredict (combinational): mis = res && ((actualTaken != predTaken_ID) || (actualTaken && actualTarget != predPC_ID)).
  - flush = mis.
  - redirectPC = actualTaken ? actualTarget : pc_ID + 4; driven 0 when mis = 0.
- Training (registered, on rising edge when res):
  - Hit at pc_ID: taken -> ctr saturating increment, target <= actualTarget; not taken -> ctr saturating decrement.
  - Hit with isJump: ctr <= ST.
  - Miss and taken: allocate/replace the entry (valid = 1, tag, target = actualTarget, ctr = isJump ? ST : WT).
  - Miss and not taken: no write.
- Saturation: ST + taken stays ST; SNT + not-taken stays SNT.
- Read/write same index in the same cycle: the IF lookup sees pre-update contents (the write lands at the clock edge).
- Perf counters:
  - branchCount += 1 on res.
  - mispredCount += 1 on mis.
  - Both wrap modulo 2^WIDTH_PERF.
- stall_ID = 1: no training, no flush, no counting. The event is taken exactly once, in the cycle the stall drops.
- PC arithmetic is modulo 2^WIDTH_PC; pc+4 wraps silently.

Decomposition:
- Shared package (param.v):
  - counter encodings CTR_SNT/WNT/WT/ST.
  - reset counter value CTR_INIT = WNT.
  - default INDEX_BITS and TAG_BITS.
  - reuse the existing WIDTH_PC.
- Sub-module sat_counter2: 2-bit saturating update, combinational next-state from (ctr, taken, force_st). Instantiated once on the update path.
- BTB arrays and perf counters stay inline.

Test Plan:
- Reset, then lookup pc_IF = 0x100 -> predTaken_IF = 0, predPC_IF = 0x104; all counters 0.
- Resolve taken branch at 0x100, target 0x40, predTaken_ID = 0 -> flush = 1, redirectPC = 0x40. Next cycle lookup 0x100 -> predTaken_IF = 1, predPC_IF = 0x40; mispredCount = 1.
- Same branch resolved taken 2 more times, then not-taken 1 time (pred 1) -> flush = 1, redirectPC = 0x104. ctr sequence WT -> ST -> ST -> WT; prediction still taken.
- jalr at 0x200 hits (ctr = ST, target 0x300), actualTarget = 0x380 -> flush = 1, redirectPC = 0x380; entry target becomes 0x380.
- Aliasing: 0x100 and 0x100 + 2^(INDEX_BITS+2) (0x140) share an index, different tag -> taken resolve at 0x140 replaces the entry; 0x100 then misses.
- Hold stall_ID = 1 for 3 cycles with resolve_valid = 1 and a mispredict -> flush = 0 and counters unchanged. On release: 1 flush, branchCount + 1. Assert rst mid-sequence -> all state cleared next edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared encodings and default geometry for the branch predictor.
// The 2-bit direction counter is a typed enum so update logic reads in state names.
package branch_predictor_pkg;

    localparam int WIDTH_PC   = 32;
    localparam int INDEX_BITS = 4;
    localparam int TAG_BITS   = 10;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT = CTR_WNT;

    // The upper counter bit is the taken/not-taken direction.
    function automatic logic ctr_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating direction counter update; force_st pins unconditional jumps to strongly-taken.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    input  logic i_force_st,
    output ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_force_st) begin
            o_ctr = CTR_ST;
        end else if (i_taken) begin
            case (i_ctr)
                CTR_SNT: o_ctr = CTR_WNT;
                CTR_WNT: o_ctr = CTR_WT;
                CTR_WT:  o_ctr = CTR_ST;
                default: o_ctr = CTR_ST;
            endcase
        end else begin
            case (i_ctr)
                CTR_ST:  o_ctr = CTR_WT;
                CTR_WT:  o_ctr = CTR_WNT;
                CTR_WNT: o_ctr = CTR_SNT;
                default: o_ctr = CTR_SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage next-PC prediction, ID-stage
// mispredict detection with flush/redirect, table training and perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH_PC   = branch_predictor_pkg::WIDTH_PC,
    parameter int INDEX_BITS = branch_predictor_pkg::INDEX_BITS,
    parameter int TAG_BITS   = branch_predictor_pkg::TAG_BITS,
    parameter int WIDTH_PERF = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_PC-1:0]   pc_IF,
    output logic                  predTaken_IF,
    output logic [WIDTH_PC-1:0]   predPC_IF,
    input  logic                  stall_ID,
    input  logic                  resolve_valid,
    input  logic                  isJump,
    input  logic [WIDTH_PC-1:0]   pc_ID,
    input  logic                  actualTaken,
    input  logic [WIDTH_PC-1:0]   actualTarget,
    input  logic                  predTaken_ID,
    input  logic [WIDTH_PC-1:0]   predPC_ID,
    output logic                  flush,
    output logic [WIDTH_PC-1:0]   redirectPC,
    output logic [WIDTH_PERF-1:0] branchCount,
    output logic [WIDTH_PERF-1:0] mispredCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [WIDTH_PC-1:0] r_target [ENTRIES];
    ctr_t                r_ctr    [ENTRIES];

    logic [WIDTH_PERF-1:0] r_branch_cnt;
    logic [WIDTH_PERF-1:0] r_mispred_cnt;

    logic [INDEX_BITS-1:0] w_idx_IF;
    logic [TAG_BITS-1:0]   w_tag_IF;
    logic                  w_hit_IF;
    logic [INDEX_BITS-1:0] w_idx_ID;
    logic [TAG_BITS-1:0]   w_tag_ID;
    logic                  w_hit_ID;
    logic                  w_res;
    logic                  w_mis;
    ctr_t                  w_ctr_next;

    assign w_idx_IF = pc_IF[INDEX_BITS+1:2];
    assign w_tag_IF = pc_IF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_hit_IF = r_valid[w_idx_IF] && (r_tag[w_idx_IF] == w_tag_IF);

    // Lookup reads the arrays combinationally, so a same-cycle update is not yet visible.
    assign predTaken_IF = !rst && w_hit_IF && ctr_taken(r_ctr[w_idx_IF]);
    assign predPC_IF    = predTaken_IF ? r_target[w_idx_IF] : pc_IF + WIDTH_PC'(4);

    assign w_idx_ID = pc_ID[INDEX_BITS+1:2];
    assign w_tag_ID = pc_ID[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_hit_ID = r_valid[w_idx_ID] && (r_tag[w_idx_ID] == w_tag_ID);

    assign w_res = resolve_valid && !stall_ID && !rst;
    assign w_mis = w_res && ((actualTaken != predTaken_ID) ||
                             (actualTaken && (actualTarget != predPC_ID)));

    assign flush      = w_mis;
    assign redirectPC = w_mis ? (actualTaken ? actualTarget : pc_ID + WIDTH_PC'(4))
                              : '0;

    sat_counter2 u_sat_counter2 (
        .i_ctr      (r_ctr[w_idx_ID]),
        .i_taken    (actualTaken),
        .i_force_st (isJump),
        .o_ctr      (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_INIT;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_res) begin
            r_branch_cnt <= r_branch_cnt + WIDTH_PERF'(1);
            if (w_mis) begin
                r_mispred_cnt <= r_mispred_cnt + WIDTH_PERF'(1);
            end
            if (w_hit_ID) begin
                r_ctr[w_idx_ID] <= w_ctr_next;
                if (actualTaken) begin
                    r_target[w_idx_ID] <= actualTarget;
                end
            end else if (actualTaken) begin
                // Not-taken misses are never allocated; they would only predict fall-through.
                r_valid[w_idx_ID]  <= 1'b1;
                r_tag[w_idx_ID]    <= w_tag_ID;
                r_target[w_idx_ID] <= actualTarget;
                r_ctr[w_idx_ID]    <= isJump ? CTR_ST : CTR_WT;
            end
        end
    end

    assign branchCount  = r_branch_cnt;
    assign mispredCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes expectations from a
// table-level reference model, a negedge monitor pops and compares.
module tb_branch_predictor;

    localparam int IDXB = 4;
    localparam int TAGB = 10;
    localparam int ENT  = 1 << IDXB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_IF = 32'h0;
    logic        predTaken_IF;
    logic [31:0] predPC_IF;
    logic        stall_ID = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        isJump = 1'b0;
    logic [31:0] pc_ID = 32'h0;
    logic        actualTaken = 1'b0;
    logic [31:0] actualTarget = 32'h0;
    logic        predTaken_ID = 1'b0;
    logic [31:0] predPC_ID = 32'h0;
    logic        flush;
    logic [31:0] redirectPC;
    logic [31:0] branchCount;
    logic [31:0] mispredCount;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc_IF         (pc_IF),
        .predTaken_IF  (predTaken_IF),
        .predPC_IF     (predPC_IF),
        .stall_ID      (stall_ID),
        .resolve_valid (resolve_valid),
        .isJump        (isJump),
        .pc_ID         (pc_ID),
        .actualTaken   (actualTaken),
        .actualTarget  (actualTarget),
        .predTaken_ID  (predTaken_ID),
        .predPC_ID     (predPC_ID),
        .flush         (flush),
        .redirectPC    (redirectPC),
        .branchCount   (branchCount),
        .mispredCount  (mispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ptk;
        logic [31:0] ppc;
        bit          fl;
        logic [31:0] rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: counter strength as an integer 0..3, taken means >= 2.
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_str   [ENT];
    logic [31:0] m_bc, m_mc;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / (4 * ENT)) % (1 << TAGB);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_str[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] p);
        t = m_hit(pc) && (m_str[idx_of(pc)] >= 2);
        p = t ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endtask

    task automatic drive(input bit r, input logic [31:0] pif, input bit rv, input bit isj,
                         input logic [31:0] pid, input bit at, input logic [31:0] atg,
                         input bit ptid, input logic [31:0] ppid, input bit st);
        exp_t        e;
        bit          res, mis;
        int unsigned ix;
        @(posedge clk);
        #1;
        rst = r; pc_IF = pif; resolve_valid = rv; isJump = isj; pc_ID = pid;
        actualTaken = at; actualTarget = atg; predTaken_ID = ptid; predPC_ID = ppid;
        stall_ID = st;
        if (r) begin
            e.ptk = 0;
            e.ppc = pif + 32'd4;
        end else begin
            m_lookup(pif, e.ptk, e.ppc);
        end
        res  = rv && !st && !r;
        mis  = res && ((at != ptid) || (at && atg != ppid));
        e.fl = mis;
        e.rd = mis ? (at ? atg : pid + 32'd4) : 32'h0;
        e.bc = m_bc;
        e.mc = m_mc;
        q.push_back(e);
        if (r) begin
            model_reset();
        end else if (res) begin
            m_bc = m_bc + 1;
            if (mis) m_mc = m_mc + 1;
            ix = idx_of(pid);
            if (m_hit(pid)) begin
                if (isj)     m_str[ix] = 3;
                else if (at) m_str[ix] = (m_str[ix] < 3) ? m_str[ix] + 1 : 3;
                else         m_str[ix] = (m_str[ix] > 0) ? m_str[ix] - 1 : 0;
                if (at) m_tgt[ix] = atg;
            end else if (at) begin
                m_valid[ix] = 1;
                m_tag[ix]   = tag_of(pid);
                m_tgt[ix]   = atg;
                m_str[ix]   = isj ? 3 : 2;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("predTaken_IF", {31'b0, predTaken_IF}, {31'b0, e.ptk});
            check("predPC_IF",    predPC_IF,             e.ppc);
            check("flush",        {31'b0, flush},        {31'b0, e.fl});
            check("redirectPC",   redirectPC,            e.rd);
            check("branchCount",  branchCount,           e.bc);
            check("mispredCount", mispredCount,          e.mc);
        end
    end

    initial begin
        bit          t;
        logic [31:0] p, pid, pif, tgt;
        model_reset();
        repeat (2) @(posedge clk);

        // reset lookup, idle
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        // first taken resolve: allocate + mispredict; same-cycle lookup still misses
        drive(0, 32'h100, 1, 0, 32'h100, 1, 32'h40, 0, 32'h104, 0);
        drive(0, 32'h100, 1, 0, 32'h100, 1, 32'h40, 1, 32'h40, 0);
        drive(0, 32'h100, 1, 0, 32'h100, 1, 32'h40, 1, 32'h40, 0);
        drive(0, 32'h100, 1, 0, 32'h100, 0, 32'h40, 1, 32'h40, 0);
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        // jalr allocation then target change
        drive(0, 32'h200, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0);
        drive(0, 32'h200, 1, 1, 32'h200, 1, 32'h380, 1, 32'h300, 0);
        drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
        // aliasing replace at 0x140
        drive(0, 32'h140, 1, 0, 32'h140, 1, 32'h500, 0, 32'h144, 0);
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0);
        // stalled mispredict, held 3 cycles then released
        repeat (3) drive(0, 32'h300, 1, 0, 32'h300, 1, 32'h700, 0, 32'h304, 1);
        drive(0, 32'h300, 1, 0, 32'h300, 1, 32'h700, 0, 32'h304, 0);
        drive(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        // wrap of pc+4 and reset in the middle of a resolve
        drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h300, 1, 0, 32'h300, 1, 32'h900, 0, 32'h304, 0);
        drive(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic over a small PC pool to force hits and aliasing
        for (int n = 0; n < 3000; n++) begin
            pif = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 3)) << 6);
            pid = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 3)) << 6);
            if ($urandom_range(0, 99) == 0) pif = 32'hFFFF_FFFC;
            tgt = 32'($urandom_range(0, 15)) << 4;
            m_lookup(pid, t, p);
            if ($urandom_range(0, 3) == 0) begin
                t = 1'($urandom_range(0, 1));
                p = 32'($urandom_range(0, 15)) << 4;
            end
            drive(($urandom_range(0, 79) == 0), pif, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), pid, 1'($urandom_range(0, 1)), tgt,
                  t, p, ($urandom_range(0, 4) == 0));
        end

        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
